aer_multi_rx: RTL and testbench

AER_MULTI_RX -- requirements
Module: aer_multi_rx

---
 rtl/aer_pkg.sv | 20 ++
 rtl/aer_evt_fifo.sv | 58 +++++
 rtl/aer_multi_rx.sv | 199 +++++++++++++++++++
 tb/tb_aer_multi_rx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/aer_pkg.sv
// Shared types and constants for the multi-channel AER receiver.
package aer_pkg;

  localparam int unsigned AER_OH_WIDTH = 8;
  // Event field widths cover the largest supported configuration (16 channels, 256-bit codes).
  localparam int unsigned AER_CH_W     = 4;
  localparam int unsigned AER_ADDR_W   = 8;

  typedef enum logic [1:0] {
    AER_IDLE  = 2'd0,
    AER_ACK   = 2'd1,
    AER_RESET = 2'd2
  } aer_rx_state_e;

  typedef struct packed {
    logic [AER_CH_W-1:0]   ch;
    logic [AER_ADDR_W-1:0] addr;
  } aer_event_t;

endpackage

// File: rtl/aer_evt_fifo.sv
// First-word-fall-through event FIFO; count and valid are registered.
module aer_evt_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   valid,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q;
  logic             push_ok_c, pop_ok_c;

  always_comb begin
    push_ok_c = push && (count_q != CNT_W'(DEPTH));
    pop_ok_c  = pop && valid_q;
    count_d   = count_q;
    if (push_ok_c && !pop_ok_c)      count_d = count_q + CNT_W'(1);
    else if (!push_ok_c && pop_ok_c) count_d = count_q - CNT_W'(1);
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      wr_q    <= wr_q + PTR_W'(push_ok_c);
      rd_q    <= rd_q + PTR_W'(pop_ok_c);
      count_q <= count_d;
      valid_q <= (count_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_q] <= push_data;
  end

  assign pop_data = mem[rd_q];
  assign valid    = valid_q;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;

endmodule

// File: rtl/aer_multi_rx.sv
// Multi-channel one-hot AER receiver: per-channel synchroniser and four-phase FSM,
// round-robin arbitration into a shared event FIFO, with ack timeout recovery.
module aer_multi_rx
  import aer_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned OH_WIDTH    = AER_OH_WIDTH,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned RST_CYC     = 4
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [NUM_CH*OH_WIDTH-1:0]                    oh_code_i,
  output logic [NUM_CH-1:0]                             ack_o,
  output logic [NUM_CH-1:0]                             aer_rst_n_o,
  output logic                                          evt_valid_o,
  input  logic                                          evt_ready_i,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] evt_ch_o,
  output logic [$clog2(OH_WIDTH)-1:0]                   evt_addr_o,
  output logic [$clog2(FIFO_DEPTH):0]                   fifo_count_o,
  output logic                                          err_onehot_o,
  output logic                                          timeout_o,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] err_ch_o
);

  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned ADDR_W = $clog2(OH_WIDTH);
  localparam int unsigned CODE_W = NUM_CH * OH_WIDTH;
  localparam int unsigned TMR_MAX = (TIMEOUT_CYC > RST_CYC) ? TIMEOUT_CYC : RST_CYC;
  localparam int unsigned TMR_W  = $clog2(TMR_MAX + 1);

  logic [CODE_W-1:0]   sync_q [SYNC_STAGES];
  logic [CODE_W-1:0]   prev_q;
  logic [CODE_W-1:0]   code_c;
  aer_rx_state_e       state_q [NUM_CH];
  aer_rx_state_e       state_d [NUM_CH];
  logic [TMR_W-1:0]    tmr_q [NUM_CH];
  logic [TMR_W-1:0]    tmr_d [NUM_CH];
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic [NUM_CH-1:0]   ack_q, ack_d, rstn_q, rstn_d;
  logic                err_q, err_d, to_q, to_d;
  logic [CH_W-1:0]     err_ch_q, err_ch_d, to_ch_c;

  logic [NUM_CH-1:0]   req_c;
  logic                gnt_valid_c;
  logic [CH_W-1:0]     gnt_ch_c, idx_c;
  logic [OH_WIDTH-1:0] gnt_code_c;
  logic                gnt_onehot_c;
  logic [ADDR_W-1:0]   gnt_addr_c;

  aer_event_t          evt_in_c, evt_head;
  logic                fifo_full;

  assign code_c = sync_q[SYNC_STAGES-1];

  // Stable-request detection and round-robin grant, blocked while the FIFO is full.
  always_comb begin
    req_c       = '0;
    gnt_valid_c = 1'b0;
    gnt_ch_c    = '0;
    idx_c       = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      req_c[c] = (state_q[c] == AER_IDLE) &&
                 (code_c[c*OH_WIDTH +: OH_WIDTH] == prev_q[c*OH_WIDTH +: OH_WIDTH]) &&
                 (|code_c[c*OH_WIDTH +: OH_WIDTH]);
    end
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx_c = CH_W'((32'(ptr_q) + i) % NUM_CH);
      if (!gnt_valid_c && !fifo_full && req_c[idx_c]) begin
        gnt_valid_c = 1'b1;
        gnt_ch_c    = idx_c;
      end
    end
    ptr_d = ptr_q;
    if (gnt_valid_c) ptr_d = CH_W'((32'(gnt_ch_c) + 1) % NUM_CH);
  end

  // One-hot check and binary encode of the granted channel's code.
  always_comb begin
    gnt_code_c   = code_c[gnt_ch_c*OH_WIDTH +: OH_WIDTH];
    gnt_onehot_c = (gnt_code_c != '0) &&
                   ((gnt_code_c & (gnt_code_c - OH_WIDTH'(1))) == '0);
    gnt_addr_c   = '0;
    for (int unsigned b = 0; b < OH_WIDTH; b++) begin
      if (gnt_code_c[b]) gnt_addr_c = ADDR_W'(b);
    end
    evt_in_c.ch   = AER_CH_W'(gnt_ch_c);
    evt_in_c.addr = AER_ADDR_W'(gnt_addr_c);
  end

  // Per-channel handshake FSMs.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    ack_d    = ack_q;
    rstn_d   = rstn_q;
    to_d     = 1'b0;
    to_ch_c  = '0;
    err_ch_d = err_ch_q;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      case (state_q[c])
        AER_IDLE: begin
          if (gnt_valid_c && (gnt_ch_c == CH_W'(c))) begin
            state_d[c] = AER_ACK;
            ack_d[c]   = 1'b1;
            tmr_d[c]   = '0;
          end
        end
        AER_ACK: begin
          if (code_c[c*OH_WIDTH +: OH_WIDTH] == '0) begin
            state_d[c] = AER_IDLE;
            ack_d[c]   = 1'b0;
          end else if (tmr_q[c] == TMR_W'(TIMEOUT_CYC - 1)) begin
            state_d[c] = AER_RESET;
            ack_d[c]   = 1'b0;
            rstn_d[c]  = 1'b0;
            tmr_d[c]   = '0;
            to_d       = 1'b1;
            to_ch_c    = CH_W'(c);
          end else begin
            tmr_d[c] = tmr_q[c] + TMR_W'(1);
          end
        end
        AER_RESET: begin
          if (tmr_q[c] == TMR_W'(RST_CYC - 1)) begin
            state_d[c] = AER_IDLE;
            rstn_d[c]  = 1'b1;
          end else begin
            tmr_d[c] = tmr_q[c] + TMR_W'(1);
          end
        end
        default: begin
          state_d[c] = AER_IDLE;
          ack_d[c]   = 1'b0;
          rstn_d[c]  = 1'b1;
        end
      endcase
    end
    err_d = gnt_valid_c && !gnt_onehot_c;
    // Timeout wins the shared channel report when both pulse together.
    if (to_d)       err_ch_d = to_ch_c;
    else if (err_d) err_ch_d = gnt_ch_c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q   <= '0;
      ptr_q    <= '0;
      ack_q    <= '0;
      rstn_q   <= '1;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
      err_ch_q <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        state_q[c] <= AER_IDLE;
        tmr_q[c]   <= '0;
      end
    end else begin
      sync_q[0] <= oh_code_i;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q   <= code_c;
      ptr_q    <= ptr_d;
      ack_q    <= ack_d;
      rstn_q   <= rstn_d;
      err_q    <= err_d;
      to_q     <= to_d;
      err_ch_q <= err_ch_d;
      state_q  <= state_d;
      tmr_q    <= tmr_d;
    end
  end

  aer_evt_fifo #(
    .WIDTH ($bits(aer_event_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (gnt_valid_c && gnt_onehot_c),
    .push_data (evt_in_c),
    .pop       (evt_valid_o && evt_ready_i),
    .pop_data  (evt_head),
    .valid     (evt_valid_o),
    .full      (fifo_full),
    .count     (fifo_count_o)
  );

  assign evt_ch_o     = CH_W'(evt_head.ch);
  assign evt_addr_o   = ADDR_W'(evt_head.addr);
  assign ack_o        = ack_q;
  assign aer_rst_n_o  = rstn_q;
  assign err_onehot_o = err_q;
  assign timeout_o    = to_q;
  assign err_ch_o     = err_ch_q;

endmodule

// File: tb/tb_aer_multi_rx.sv
// Directed bench for aer_multi_rx with default parameters (4 channels, 8-bit codes, depth 8).
module tb_aer_multi_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] oh_code;
  logic [3:0]  ack, aer_rst_n;
  logic        evt_valid, evt_ready;
  logic [1:0]  evt_ch;
  logic [2:0]  evt_addr;
  logic [3:0]  fifo_count;
  logic        err_onehot, timeout;
  logic [1:0]  err_ch;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  aer_multi_rx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .oh_code_i    (oh_code),
    .ack_o        (ack),
    .aer_rst_n_o  (aer_rst_n),
    .evt_valid_o  (evt_valid),
    .evt_ready_i  (evt_ready),
    .evt_ch_o     (evt_ch),
    .evt_addr_o   (evt_addr),
    .fifo_count_o (fifo_count),
    .err_onehot_o (err_onehot),
    .timeout_o    (timeout),
    .err_ch_o     (err_ch)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input int ch, input logic lvl, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      step();
      if (ack[ch] === lvl) seen = 1'b1;
    end
    chk(tag, 32'(seen), 1);
  endtask

  task automatic send(input int ch, input logic [7:0] code);
    oh_code[ch*8 +: 8] = code;
    wait_ack(ch, 1'b1, "seq_ack");
    oh_code[ch*8 +: 8] = 8'h00;
    wait_ack(ch, 1'b0, "seq_release");
  endtask

  initial begin
    rst_n     = 1'b0;
    oh_code   = '0;
    evt_ready = 1'b1;
    repeat (3) step();
    chk("rst_ack",       32'(ack), 0);
    chk("rst_aer_rst_n", 32'(aer_rst_n), 15);
    chk("rst_valid",     32'(evt_valid), 0);
    chk("rst_count",     32'(fifo_count), 0);
    chk("rst_err",       32'(err_onehot), 0);
    chk("rst_timeout",   32'(timeout), 0);
    chk("rst_err_ch",    32'(err_ch), 0);
    rst_n = 1'b1;

    // Single event on channel 2, index 3
    oh_code[23:16] = 8'h08;
    repeat (3) step();
    chk("lat_ack_early", 32'(ack), 0);
    step();
    chk("lat_ack",   32'(ack), 4);
    chk("lat_valid", 32'(evt_valid), 1);
    chk("lat_ch",    32'(evt_ch), 2);
    chk("lat_addr",  32'(evt_addr), 3);
    chk("lat_count", 32'(fifo_count), 1);
    step();
    chk("pop_count", 32'(fifo_count), 0);
    chk("pop_valid", 32'(evt_valid), 0);
    oh_code[23:16] = 8'h00;
    repeat (2) step();
    chk("rel_ack_hold", 32'(ack), 4);
    step();
    chk("rel_ack_drop", 32'(ack), 0);

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;

    // Contention on channels 0, 1, 3 with the sink always ready
    oh_code = {8'h80, 8'h00, 8'h02, 8'h01};
    repeat (4) step();
    chk("cont_ack0",  32'(ack), 1);
    chk("cont_ch0",   32'(evt_ch), 0);
    chk("cont_addr0", 32'(evt_addr), 0);
    step();
    chk("cont_ack1",   32'(ack), 3);
    chk("cont_ch1",    32'(evt_ch), 1);
    chk("cont_addr1",  32'(evt_addr), 1);
    chk("cont_count1", 32'(fifo_count), 1);
    step();
    chk("cont_ack3",   32'(ack), 11);
    chk("cont_ch3",    32'(evt_ch), 3);
    chk("cont_addr3",  32'(evt_addr), 7);
    chk("cont_count3", 32'(fifo_count), 1);
    step();
    chk("cont_drained", 32'(fifo_count), 0);
    oh_code = '0;
    repeat (3) step();
    chk("cont_release", 32'(ack), 0);

    // Reset while three events are queued and acks are high
    evt_ready = 1'b0;
    oh_code   = {8'h80, 8'h00, 8'h02, 8'h01};
    repeat (6) step();
    chk("mid_ack",   32'(ack), 11);
    chk("mid_count", 32'(fifo_count), 3);
    rst_n = 1'b0;
    step();
    chk("mid_rst_ack",   32'(ack), 0);
    chk("mid_rst_count", 32'(fifo_count), 0);
    chk("mid_rst_valid", 32'(evt_valid), 0);
    oh_code = '0;
    step();
    rst_n = 1'b1;

    // Backpressure: eight events fill the FIFO, the ninth must wait
    for (int k = 0; k < 8; k++) send(k % 4, 8'(1 << k));
    chk("bp_full_count", 32'(fifo_count), 8);
    oh_code[7:0] = 8'h01;
    repeat (10) step();
    chk("bp_withheld",    32'(ack), 0);
    chk("bp_count_stuck", 32'(fifo_count), 8);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    chk("bp_pop_count", 32'(fifo_count), 7);
    chk("bp_pop_noack", 32'(ack), 0);
    step();
    chk("bp_late_ack",   32'(ack), 1);
    chk("bp_late_count", 32'(fifo_count), 8);
    oh_code[7:0] = 8'h00;
    repeat (3) step();
    chk("bp_release", 32'(ack), 0);
    evt_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk("bp_drain_valid", 32'(evt_valid), 1);
      chk("bp_drain_ch",    32'(evt_ch), 32'(k % 4));
      chk("bp_drain_addr",  32'(evt_addr), 32'(k % 8));
      step();
    end
    chk("bp_empty_count", 32'(fifo_count), 0);
    chk("bp_empty_valid", 32'(evt_valid), 0);

    // Non-one-hot code on channel 1
    oh_code[15:8] = 8'h21;
    repeat (4) step();
    chk("bad_ack",    32'(ack), 2);
    chk("bad_err",    32'(err_onehot), 1);
    chk("bad_err_ch", 32'(err_ch), 1);
    chk("bad_count",  32'(fifo_count), 0);
    chk("bad_valid",  32'(evt_valid), 0);
    step();
    chk("bad_err_pulse", 32'(err_onehot), 0);
    oh_code[15:8] = 8'h00;
    repeat (3) step();
    chk("bad_release", 32'(ack), 0);

    // Channel 3 never releases: timeout and transmitter reset
    oh_code[31:24] = 8'h10;
    repeat (4) step();
    chk("to_ack",  32'(ack), 8);
    chk("to_ch",   32'(evt_ch), 3);
    chk("to_addr", 32'(evt_addr), 4);
    repeat (254) step();
    chk("to_ack_hold", 32'(ack), 8);
    chk("to_no_pulse", 32'(timeout), 0);
    step();
    chk("to_ack_drop",  32'(ack), 0);
    chk("to_pulse",     32'(timeout), 1);
    chk("to_err_ch",    32'(err_ch), 3);
    chk("to_rst_first", 32'(aer_rst_n), 7);
    oh_code[31:24] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to_rst_low",   32'(aer_rst_n), 7);
      chk("to_pulse_end", 32'(timeout), 0);
    end
    step();
    chk("to_rst_high", 32'(aer_rst_n), 15);
    repeat (6) step();
    chk("to_idle_ack",   32'(ack), 0);
    chk("to_idle_count", 32'(fifo_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
